// File: rtl/tbuf_bus_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
// Latency: n/a (types, constants, and combinational functions only).
// Backpressure: n/a.
// Contents: FSM state enum, round-robin pick function, one-hot decode, counter width helper.
package tbuf_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    // Widest supported requester count; helpers operate at this width and
    // callers zero-extend / truncate to their own N.
    localparam int MAX_N = 16;
    localparam int PTR_W = 4;

    // Counter width able to hold 0..maxv-1, never narrower than one bit.
    function automatic int cnt_w(input int maxv);
        return (maxv > 1) ? $clog2(maxv) : 1;
    endfunction

    // One-hot grant for the first requester at or after ptr, wrapping n-1 -> 0.
    function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input logic [PTR_W-1:0] ptr,
                                                 input int               n);
        logic [MAX_N-1:0] gnt;
        logic             found;
        int               idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return gnt;
    endfunction

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tbuf_rr_arbiter.sv
// Round-robin pick with a registered priority pointer.
// Latency: pick_o is combinational from req_i and the pointer; the pointer updates one edge after upd_i.
// Backpressure: none; the caller decides when to take the pick and when to advance the pointer.
// Ports: clk_i, rst_i (sync, active-high), req_i[N], upd_i (advance pointer past owner_i),
//        owner_i (index of the releasing owner), pick_o[N] (one-hot, zero when no request).
import tbuf_bus_pkg::*;

module tbuf_rr_arbiter #(
    parameter int N = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             upd_i,
    input  logic [PTR_W-1:0] owner_i,
    output logic [N-1:0]     pick_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [MAX_N-1:0] pick_full;

    assign pick_full = rr_pick(MAX_N'(req_i), ptr_q, N);
    assign pick_o    = pick_full[N-1:0];

    // Bits above N are always zero because the request is zero-extended.
    if (N < MAX_N) begin : g_pick_hi
        logic unused_pick_hi;
        assign unused_pick_hi = |pick_full[MAX_N-1:N];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = (owner_i == PTR_W'(N - 1)) ? '0 : owner_i + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// N-channel tristate bus owner: round-robin grant, hold limit, high-Z turnaround between owners.
// Latency: grant/OE one edge after arbitration in IDLE; Y follows the owner's A combinationally.
// Backpressure: owner holds the bus at most MAX_HOLD cycles; losers keep REQ high (nothing is latched).
// Ports: CLK, RST (sync, active-high), REQ[N], A[N*W] (channel i at [i*W +: W]),
//        GNT[N] one-hot, OE, Y[W] tristate bus, BUSY (DRIVE or TURN).
// Option: TBUF_BUS_KEEPER_EN holds the last driven value on Y instead of Z while OE=0.
import tbuf_bus_pkg::*;

module tbuf_bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter bit INVERT   = 1'b1,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   REQ,
    input  logic [N*W-1:0] A,
    output logic [N-1:0]   GNT,
    output logic           OE,
    output logic [W-1:0]   Y,
    output logic           BUSY
);

    localparam int HOLD_W = cnt_w(MAX_HOLD);
    localparam int TURN_W = cnt_w(TURN_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic              oe_q, oe_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;

    logic [N-1:0]      pick;
    logic              ptr_upd;
    logic [PTR_W-1:0]  owner_idx;
    logic              owner_req;
    logic [W-1:0]      a_owner;
    logic [W-1:0]      drive;

    assign owner_idx = onehot_to_idx(MAX_N'(gnt_q));
    assign owner_req = |(REQ & gnt_q);

    tbuf_rr_arbiter #(
        .N (N)
    ) u_rr (
        .clk_i   (CLK),
        .rst_i   (RST),
        .req_i   (REQ),
        .upd_i   (ptr_upd),
        .owner_i (owner_idx),
        .pick_o  (pick)
    );

    // gnt_q is one-hot or zero, so an AND-OR mux selects the owner's data.
    always_comb begin
        a_owner = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) a_owner = a_owner | A[i*W +: W];
        end
    end

    assign drive = INVERT ? ~a_owner : a_owner;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        oe_d    = oe_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        ptr_upd = 1'b0;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    state_d = DRIVE;
                    gnt_d   = pick;
                    oe_d    = 1'b1;
                    hold_d  = '0;
                end
            end
            DRIVE: begin
                // Saturating: the exit below fires at HOLD_LAST, so the
                // counter never needs to wrap.
                hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
                if (!owner_req || hold_q == HOLD_LAST) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    oe_d    = 1'b0;
                    turn_d  = '0;
                    ptr_upd = 1'b1;
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // Reset releases the bus on the very next edge, skipping the turnaround.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            oe_q    <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            oe_q    <= oe_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    assign GNT  = gnt_q;
    assign OE   = oe_q;
    assign BUSY = (state_q == DRIVE) || (state_q == TURN);

`ifdef TBUF_BUS_KEEPER_EN
    logic [W-1:0] keep_q;

    // oe_q is high exactly in DRIVE, so this captures every driven cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            keep_q <= '0;
        end else if (oe_q) begin
            keep_q <= drive;
        end
    end

    assign Y = oe_q ? drive : keep_q;
`else
    assign Y = oe_q ? drive : {W{1'bz}};
`endif

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed self-checking bench for tbuf_bus_arbiter (N=4, W=8, INVERT=1, TURN_CYC=1, MAX_HOLD=16).
// Inputs change 1ns after the rising edge and outputs are sampled at the same point.
// Keeper checks switch on TBUF_BUS_KEEPER_EN.
module tb_tbuf_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] a   = 32'h0;
    wire  [3:0]  gnt;
    wire         oe;
    wire  [7:0]  y;
    wire         busy;

    int total = 0;
    int bad   = 0;

    tbuf_bus_arbiter #(
        .N        (4),
        .W        (8),
        .INVERT   (1'b1),
        .TURN_CYC (1),
        .MAX_HOLD (16)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .REQ  (req),
        .A    (a),
        .GNT  (gnt),
        .OE   (oe),
        .Y    (y),
        .BUSY (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_wait_idle: busy=%b required 0 within 100 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++;
        if (oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", oe); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef TBUF_BUS_KEEPER_EN
        total++;
        if (y !== 8'h00) begin bad++; $display("FAIL reset_keeper_y: got %h want 00", y); end
`endif
        rst = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
        total++;
        if (oe !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL reset_first_oe_busy: got oe=%b busy=%b want 1 1", oe, busy);
        end
        req = 4'b0000;
        wait_idle("reset");
    endtask

    task automatic test_single();
        a   = 32'h003C_0000;
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        total++;
        if (y !== 8'hC3) begin bad++; $display("FAIL single_y: got %h want c3", y); end
        // Same-cycle data path: Y tracks A without waiting for an edge.
        a = 32'h000F_0000;
        #1;
        total++;
        if (y !== 8'hF0) begin bad++; $display("FAIL single_y_comb: got %h want f0", y); end
        req = 4'b0000;
        tick();
        total++;
        if (gnt !== 4'b0000 || oe !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_turn: got gnt=%b oe=%b busy=%b want 0000 0 1", gnt, oe, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || oe !== 1'b0) begin
            bad++; $display("FAIL single_idle: got busy=%b oe=%b want 0 0", busy, oe);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [7:0] exp_y [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_y = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hEE};
        a   = 32'h4433_2211;
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            total++;
            if (gnt !== exp_g[g] || y !== exp_y[g]) begin
                bad++; $display("FAIL rr_start_%0d: got gnt=%b y=%h want %b %h", g, gnt, y, exp_g[g], exp_y[g]);
            end
            repeat (15) tick();
            total++;
            if (gnt !== exp_g[g]) begin
                bad++; $display("FAIL rr_hold_%0d: got gnt=%b want %b at 16th cycle", g, gnt, exp_g[g]);
            end
            if (g < 4) begin
                tick();
                total++;
                if (gnt !== 4'b0000 || busy !== 1'b1) begin
                    bad++; $display("FAIL rr_turn_%0d: got gnt=%b busy=%b want 0000 1", g, gnt, busy);
                end
                tick();
                total++;
                if (gnt !== 4'b0000 || busy !== 1'b0) begin
                    bad++; $display("FAIL rr_idle_%0d: got gnt=%b busy=%b want 0000 0", g, gnt, busy);
                end
                tick();
            end
        end
        req = 4'b0000;
        wait_idle("rr");
    endtask

    task automatic test_mid_reset();
        // Move the pointer to 2 so that a surviving pointer would pick ch2 below.
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL midrst_pre_gnt: got %b want 0010", gnt); end
        req = 4'b0000;
        wait_idle("midrst_pre");
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL midrst_ch2_gnt: got %b want 0100", gnt); end
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0000 || oe !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_release: got gnt=%b oe=%b busy=%b want 0000 0 0", gnt, oe, busy);
        end
        rst = 1'b0;
        req = 4'b0101;
        tick();
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL midrst_ptr0: got %b want 0001", gnt); end
        req = 4'b0000;
        wait_idle("midrst");
    endtask

    task automatic test_hold_limit();
        // Pointer is 1 here; ch1 is the sole requester.
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL hold_first_gnt: got %b want 0010", gnt); end
        repeat (15) tick();
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL hold_last_cycle: got %b want 0010", gnt); end
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            bad++; $display("FAIL hold_turn: got gnt=%b busy=%b want 0000 1", gnt, busy);
        end
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL hold_idle: got gnt=%b busy=%b want 0000 0", gnt, busy);
        end
        tick();
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL hold_regrant: got %b want 0010", gnt); end
        // Drop REQ in the very cycle the hold limit is reached.
        repeat (15) tick();
        req = 4'b0000;
        tick();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            bad++; $display("FAIL hold_drop_turn: got gnt=%b busy=%b want 0000 1", gnt, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL hold_drop_idle: got busy=%b want 0", busy); end
        tick();
        total++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            bad++; $display("FAIL hold_drop_stay: got busy=%b gnt=%b want 0 0000", busy, gnt);
        end
    endtask

    task automatic test_keeper();
        a   = 32'h0000_5A00;
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010 || y !== 8'hA5) begin
            bad++; $display("FAIL keep_drive: got gnt=%b y=%h want 0010 a5", gnt, y);
        end
        req = 4'b0000;
        tick();
        a = 32'h0000_0000;
        #1;
        for (int c = 0; c < 2; c++) begin
            total++;
`ifdef TBUF_BUS_KEEPER_EN
            if (oe !== 1'b0 || y !== 8'hA5) begin
                bad++; $display("FAIL keep_hold_%0d: got oe=%b y=%h want 0 a5", c, oe, y);
            end
`else
            if (oe !== 1'b0) begin
                bad++; $display("FAIL keep_release_%0d: got oe=%b want 0", c, oe);
            end
`endif
            tick();
        end
    endtask

    task automatic test_contention();
        logic [3:0] prev1;
        logic [3:0] prev2;
        logic [7:0] exp_y;
        int         own_n;
        prev1 = 4'b0000;
        prev2 = 4'b0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 4 == 0) req = 4'($urandom_range(0, 15));
            a = $urandom;
            tick();
            own_n = 0;
            exp_y = 8'h00;
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    own_n++;
                    exp_y = ~a[i*8 +: 8];
                end
            end
            total++;
            if (own_n > 1) begin bad++; $display("FAIL cont_onehot_%0d: gnt=%b more than one owner", cyc, gnt); end
            total++;
            if (oe !== (|gnt)) begin bad++; $display("FAIL cont_oe_%0d: oe=%b want %b", cyc, oe, |gnt); end
            if (oe === 1'b1) begin
                total++;
                if (y !== exp_y) begin bad++; $display("FAIL cont_y_%0d: y=%h want %h", cyc, y, exp_y); end
            end
            // Owners may not change without the turnaround plus arbitration gap.
            total++;
            if ((gnt !== 4'b0000 && prev1 !== 4'b0000 && gnt !== prev1) ||
                (gnt !== 4'b0000 && prev1 === 4'b0000 && prev2 !== 4'b0000)) begin
                bad++; $display("FAIL cont_gap_%0d: gnt=%b prev=%b prev2=%b", cyc, gnt, prev1, prev2);
            end
            prev2 = prev1;
            prev1 = gnt;
        end
        req = 4'b0000;
        wait_idle("cont");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mid_reset();
        test_hold_limit();
        test_keeper();
        test_contention();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
